// File: rtl/hwce_wmem_xbar_pkg.sv
// Shared helpers and types for the HWCE weight-memory arbitrated crossbar.
// Optional stall statistics are enabled with the macro HWCE_WMEM_XBAR_STATS_EN.
package hwce_wmem_xbar_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefBeW   = DefDataW / 8;

  function automatic int unsigned sel_w(int unsigned n_slaves);
    return $clog2(n_slaves);
  endfunction

  function automatic int unsigned mid_w(int unsigned addr_w, int unsigned n_slaves);
    return addr_w - sel_w(n_slaves);
  endfunction

  // n_slaves is a power of two, so n_slaves-1 is the select mask.
  function automatic int unsigned bank_sel(logic [63:0] add, int unsigned lsb,
                                           int unsigned n_slaves);
    return 32'((add >> lsb) & 64'(n_slaves - 1));
  endfunction

  typedef struct packed {
    logic                req;
    logic [DefAddrW-1:0] add;
    logic                wen;
    logic [DefDataW-1:0] wdata;
    logic [DefBeW-1:0]   be;
  } mst_req_t;

  typedef struct packed {
    logic                r_valid;
    logic [DefDataW-1:0] r_rdata;
  } mst_rsp_t;

endpackage

// File: rtl/hwce_wmem_rr_arb.sv
// Round-robin arbiter for one weight-memory bank: one-hot grant plus winner index.
// Search starts at ptr_q; ptr_q advances past the winner only when a grant is issued.
module hwce_wmem_rr_arb #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      cand = (32'(ptr_q) + i) % N_MASTERS;
      if (!found && req_i[IDX_W'(cand)]) begin
        found                = 1'b1;
        gnt_o[IDX_W'(cand)]  = 1'b1;
        idx_o                = IDX_W'(cand);
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (32'(idx_o) + 1 == N_MASTERS) ? '0 : IDX_W'(32'(idx_o) + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hwce_wmem_arb_xbar.sv
// Address-decoded, per-bank round-robin crossbar from HWCE weight loaders to WMEM banks.
// Define HWCE_WMEM_XBAR_STATS_EN to build the per-master saturating stall counters.
module hwce_wmem_arb_xbar
  import hwce_wmem_xbar_pkg::*;
#(
  parameter int unsigned N_MASTERS  = 4,
  parameter int unsigned N_SLAVES   = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned LSB_ADDR   = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [N_MASTERS-1:0]                                m_req_i,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]                     m_add_i,
  input  logic [N_MASTERS-1:0]                                m_wen_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]                     m_wdata_i,
  input  logic [N_MASTERS*BE_WIDTH-1:0]                       m_be_i,
  output logic [N_MASTERS-1:0]                                m_gnt_o,
  output logic [N_MASTERS-1:0]                                m_r_valid_o,
  output logic [N_MASTERS*DATA_WIDTH-1:0]                     m_r_rdata_o,
  output logic [N_SLAVES-1:0]                                 s_req_o,
  output logic [N_SLAVES*mid_w(ADDR_WIDTH, N_SLAVES)-1:0]     s_add_o,
  output logic [N_SLAVES-1:0]                                 s_wen_o,
  output logic [N_SLAVES*DATA_WIDTH-1:0]                      s_wdata_o,
  output logic [N_SLAVES*BE_WIDTH-1:0]                        s_be_o,
  input  logic [N_SLAVES*DATA_WIDTH-1:0]                      s_r_rdata_i,
  input  logic                                                stat_clr_i,
  output logic [N_MASTERS*CNT_WIDTH-1:0]                      stall_cnt_o
);

  localparam int unsigned SelW = sel_w(N_SLAVES);
  localparam int unsigned MidW = mid_w(ADDR_WIDTH, N_SLAVES);
  localparam int unsigned IdxW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LoMask = (ADDR_WIDTH'(1) << LSB_ADDR) - ADDR_WIDTH'(1);

  logic [SelW-1:0]       m_bank [N_MASTERS];
  logic [MidW-1:0]       m_sadd [N_MASTERS];
  logic [ADDR_WIDTH-1:0] add_tmp, cut_tmp;
  logic [N_MASTERS-1:0]  bank_req [N_SLAVES];
  logic [N_MASTERS-1:0]  bank_gnt [N_SLAVES];
  logic [IdxW-1:0]       bank_idx [N_SLAVES];
  logic [IdxW-1:0]       win;

  logic [N_MASTERS-1:0]           r_valid_q;
  logic [N_MASTERS-1:0][SelW-1:0] bank_q;

  // Decode bank and strip the select bits from each master address.
  always_comb begin
    add_tmp = '0;
    cut_tmp = '0;
    for (int unsigned n = 0; n < N_MASTERS; n++) begin
      add_tmp   = m_add_i[n*ADDR_WIDTH +: ADDR_WIDTH];
      m_bank[n] = SelW'(bank_sel(64'(add_tmp), LSB_ADDR, N_SLAVES));
      cut_tmp   = ((add_tmp >> (LSB_ADDR + SelW)) << LSB_ADDR) | (add_tmp & LoMask);
      m_sadd[n] = cut_tmp[MidW-1:0];
    end
    for (int unsigned b = 0; b < N_SLAVES; b++) begin
      for (int unsigned n = 0; n < N_MASTERS; n++) begin
        bank_req[b][n] = m_req_i[n] && (32'(m_bank[n]) == b);
      end
    end
  end

  for (genvar b = 0; b < N_SLAVES; b++) begin : g_bank
    hwce_wmem_rr_arb #(
      .N_MASTERS(N_MASTERS),
      .IDX_W    (IdxW)
    ) u_arb (
      .clk  (clk),
      .rst  (rst),
      .req_i(bank_req[b]),
      .gnt_o(bank_gnt[b]),
      .idx_o(bank_idx[b])
    );
  end

  always_comb begin
    m_gnt_o   = '0;
    s_req_o   = '0;
    s_add_o   = '0;
    s_wen_o   = '0;
    s_wdata_o = '0;
    s_be_o    = '0;
    win       = '0;
    for (int unsigned b = 0; b < N_SLAVES; b++) begin
      s_req_o[b] = |bank_req[b];
      m_gnt_o    = m_gnt_o | bank_gnt[b];
      if (s_req_o[b]) begin
        win                                 = bank_idx[b];
        s_add_o[b*MidW +: MidW]             = m_sadd[win];
        s_wen_o[b]                          = m_wen_i[win];
        s_wdata_o[b*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[32'(win)*DATA_WIDTH +: DATA_WIDTH];
        s_be_o[b*BE_WIDTH +: BE_WIDTH]      = m_be_i[32'(win)*BE_WIDTH +: BE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_q <= '0;
      bank_q    <= '0;
    end else begin
      r_valid_q <= m_gnt_o;
      for (int unsigned n = 0; n < N_MASTERS; n++) begin
        if (m_gnt_o[n]) bank_q[n] <= m_bank[n];
      end
    end
  end

  assign m_r_valid_o = r_valid_q;

  always_comb begin
    m_r_rdata_o = '0;
    for (int unsigned n = 0; n < N_MASTERS; n++) begin
      if (r_valid_q[n]) begin
        m_r_rdata_o[n*DATA_WIDTH +: DATA_WIDTH] =
            s_r_rdata_i[32'(bank_q[n])*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef HWCE_WMEM_XBAR_STATS_EN
  logic [N_MASTERS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Clear has priority over increment; counters saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned n = 0; n < N_MASTERS; n++) begin
      if (stat_clr_i) begin
        cnt_d[n] = '0;
      end else if (m_req_i[n] && !m_gnt_o[n] && (cnt_q[n] != '1)) begin
        cnt_d[n] = cnt_q[n] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stall_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_hwce_wmem_arb_xbar.sv
// Self-checking bench for hwce_wmem_arb_xbar (4 masters, 8 banks, LSB_ADDR=2, CNT_WIDTH=4).
module tb_hwce_wmem_arb_xbar;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [3:0]       req, wen;
  logic [3:0][31:0] add, wdata;
  logic [3:0][3:0]  be;
  logic [7:0][31:0] srd;

  logic [3:0]       gnt, rv;
  logic [3:0][31:0] rdata;
  logic [7:0]       sreq, swen;
  logic [7:0][28:0] sadd;
  logic [7:0][31:0] swdata;
  logic [7:0][3:0]  sbe;
  logic [3:0][3:0]  scnt;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  bit run    = 1'b0;

  hwce_wmem_arb_xbar #(
    .N_MASTERS (4),
    .N_SLAVES  (8),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .LSB_ADDR  (2),
    .CNT_WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_req_i    (req),
    .m_add_i    (add),
    .m_wen_i    (wen),
    .m_wdata_i  (wdata),
    .m_be_i     (be),
    .m_gnt_o    (gnt),
    .m_r_valid_o(rv),
    .m_r_rdata_o(rdata),
    .s_req_o    (sreq),
    .s_add_o    (sadd),
    .s_wen_o    (swen),
    .s_wdata_o  (swdata),
    .s_be_o     (sbe),
    .s_r_rdata_i(srd),
    .stat_clr_i (clr),
    .stall_cnt_o(scnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end else begin
      passes++;
    end
  endtask

  // Reference model: per-bank pointer, pending response, stall count.
  int         mptr [8];
  logic [3:0] mval;
  int         mbank[4];
  int         mcnt [4];
  logic [3:0] e_gnt;
  int         e_win[8];

  function automatic int bank_of(logic [31:0] a);
    return int'((a >> 2) & 32'd7);
  endfunction

  // Winner is the requester nearest to the pointer going upward, modulo 4.
  task automatic model_arb();
    int d, bestd;
    e_gnt = '0;
    for (int b = 0; b < 8; b++) begin
      e_win[b] = -1;
      bestd    = 99;
      for (int n = 0; n < 4; n++) begin
        if (req[n] && bank_of(add[n]) == b) begin
          d = (n - mptr[b] + 4) % 4;
          if (d < bestd) begin
            bestd    = d;
            e_win[b] = n;
          end
        end
      end
      if (e_win[b] >= 0) e_gnt[e_win[b]] = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 8; b++) mptr[b] = 0;
      for (int n = 0; n < 4; n++) begin
        mbank[n] = 0;
        mcnt[n]  = 0;
      end
      mval = '0;
    end else begin
      model_arb();
      for (int b = 0; b < 8; b++) if (e_win[b] >= 0) mptr[b] = (e_win[b] + 1) % 4;
      for (int n = 0; n < 4; n++) begin
        if (e_gnt[n]) mbank[n] = bank_of(add[n]);
        if (clr) mcnt[n] = 0;
        else if (req[n] && !e_gnt[n] && mcnt[n] < 15) mcnt[n] = mcnt[n] + 1;
      end
      mval = e_gnt;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      logic [7:0]       x_req, x_wen;
      logic [7:0][28:0] x_add;
      logic [7:0][31:0] x_wd;
      logic [7:0][3:0]  x_be;
      logic [3:0][31:0] x_rd;
      logic [3:0][3:0]  x_cnt;
      logic [31:0]      a;
      model_arb();
      x_req = '0; x_wen = '0; x_add = '0; x_wd = '0; x_be = '0; x_rd = '0; x_cnt = '0;
      for (int b = 0; b < 8; b++) begin
        if (e_win[b] >= 0) begin
          a        = add[e_win[b]];
          x_req[b] = 1'b1;
          x_wen[b] = wen[e_win[b]];
          x_add[b] = {a[31:5], a[1:0]};
          x_wd[b]  = wdata[e_win[b]];
          x_be[b]  = be[e_win[b]];
        end
      end
      for (int n = 0; n < 4; n++) begin
        if (mval[n]) x_rd[n] = srd[mbank[n]];
`ifdef HWCE_WMEM_XBAR_STATS_EN
        x_cnt[n] = 4'(mcnt[n]);
`endif
      end
      chk("m_gnt", 64'(gnt), 64'(e_gnt));
      chk("s_req", 64'(sreq), 64'(x_req));
      chk("s_wen", 64'(swen), 64'(x_wen));
      chk("s_be", 64'(sbe), 64'(x_be));
      for (int b = 0; b < 8; b++) begin
        chk("s_add", 64'(sadd[b]), 64'(x_add[b]));
        chk("s_wdata", 64'(swdata[b]), 64'(x_wd[b]));
      end
      chk("m_r_valid", 64'(rv), 64'(mval));
      for (int n = 0; n < 4; n++) chk("m_r_rdata", 64'(rdata[n]), 64'(x_rd[n]));
      chk("stall_cnt", 64'(scnt), 64'(x_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; wen = '0; add = '0; wdata = '0; be = '0;
  endtask

  task automatic set_m(int n, logic [31:0] a, logic w, logic [31:0] d, logic [3:0] e);
    req[n] = 1'b1; add[n] = a; wen[n] = w; wdata[n] = d; be[n] = e;
  endtask

  int order[8];
  int exp_order[8];
  int exp_c3, exp_c15;

  initial begin
    idle();
    for (int b = 0; b < 8; b++) srd[b] = 32'hCAFE0000 + 32'(b);
`ifdef HWCE_WMEM_XBAR_STATS_EN
    exp_c3 = 3; exp_c15 = 15;
`else
    exp_c3 = 0; exp_c15 = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run = 1'b1;
    @(negedge clk);
    chk("reset r_valid", 64'(rv), 64'h0);
    chk("reset gnt", 64'(gnt), 64'h0);
    chk("reset s_req", 64'(sreq), 64'h0);
    chk("reset stall_cnt", 64'(scnt), 64'h0);
    step();

    // Single load to bank 1.
    set_m(0, 32'h04, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    chk("load gnt0", 64'(gnt), 64'h1);
    chk("load s_req1", 64'(sreq), 64'h02);
    step();
    idle();
    @(negedge clk);
    chk("load r_valid0", 64'(rv), 64'h1);
    chk("load rdata0", 64'(rdata[0]), 64'hCAFE0001);
    step();

    // All four masters hammer bank 3.
    for (int n = 0; n < 4; n++) set_m(n, 32'h0C, 1'b1, 32'h0, 4'hF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      order[k] = -1;
      for (int n = 0; n < 4; n++) if (gnt[n]) order[k] = n;
      chk("rr one s_req", 64'(sreq), 64'h08);
      step();
    end
    idle();
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int k = 0; k < 8; k++) chk("rr order", 64'(order[k]), 64'(exp_order[k]));

    // Distinct banks granted together.
    set_m(0, 32'h00, 1'b1, 32'h0, 4'hF);
    set_m(1, 32'h04, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    chk("parallel gnt", 64'(gnt), 64'h3);
    step();
    idle();
    @(negedge clk);
    chk("parallel r_valid", 64'(rv), 64'h3);
    chk("parallel rdata0", 64'(rdata[0]), 64'hCAFE0000);
    chk("parallel rdata1", 64'(rdata[1]), 64'hCAFE0001);
    step();

    // Store from M2 to bank 7.
    set_m(2, 32'h1C, 1'b0, 32'h1234, 4'b0011);
    @(negedge clk);
    chk("store s_req7", 64'(sreq), 64'h80);
    chk("store s_wen7", 64'(swen[7]), 64'h0);
    chk("store s_be7", 64'(sbe[7]), 64'h3);
    chk("store s_wdata7", 64'(swdata[7]), 64'h1234);
    chk("store s_add7", 64'(sadd[7]), 64'h0);
    step();
    idle();
    @(negedge clk);
    chk("store r_valid2", 64'(rv), 64'h4);
    step();

    // Move bank3 pointer off zero, then reset right after a grant.
    set_m(1, 32'h0C, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    chk("pre-rst gnt1", 64'(gnt), 64'h2);
    step();
    idle();
    set_m(0, 32'h08, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    chk("pre-rst gnt0", 64'(gnt), 64'h1);
    step();
    idle();
    rst = 1'b1;
    #1;
    chk("rst drops r_valid", 64'(rv), 64'h0);
    @(negedge clk);
    chk("rst holds r_valid", 64'(rv), 64'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst r_valid", 64'(rv), 64'h0);
    step();
    for (int n = 0; n < 4; n++) set_m(n, 32'h0C, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    chk("post-rst ptr restart", 64'(gnt), 64'h1);
    step();
    idle();

    // Stall statistics on bank 5.
    clr = 1'b1;
    step();
    clr = 1'b0;
    set_m(1, 32'h14, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    chk("stat setup gnt1", 64'(gnt), 64'h2);
    step();
    for (int n = 0; n < 4; n++) set_m(n, 32'h14, 1'b1, 32'h0, 4'hF);
    repeat (4) step();
    @(negedge clk);
    chk("stall_cnt1 three", 64'(scnt[1]), 64'(exp_c3));
    step();
    repeat (28) step();
    @(negedge clk);
    chk("stall_cnt1 saturate", 64'(scnt[1]), 64'(exp_c15));
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    idle();
    @(negedge clk);
    chk("stall_cnt1 clear", 64'(scnt[1]), 64'h0);
    step();
    step();

    run = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
